// File: rtl/exu_commit_bjp_pkg.sv
// Shared constants for the branch/jump commit unit: FSM encodings and counter width.
package exu_commit_bjp_pkg;

  localparam logic [0:0] CMT_ST_IDLE  = 1'b0;
  localparam logic [0:0] CMT_ST_FLUSH = 1'b1;

  localparam int CMT_CNT_W = 32;

  // Branch/jump redirect distance for a not-taken resolution.
  localparam int CMT_INSN_BYTES = 4;

endpackage

// File: rtl/exu_cmt_cnt.sv
// Wrap-around statistics counter with enable and synchronous reset.
module exu_cmt_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Natural modulo-2^W add gives the all-ones to zero wrap.
  assign cnt_d = en_i ? cnt_q + W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/exu_commit_bjp.sv
// Branch/jump commit unit: detects mispredicts, kills younger work and
// holds a redirect request toward the IFU until it is accepted.
module exu_commit_bjp
  import exu_commit_bjp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_SIZE = 32,
  parameter int CNT_W   = CMT_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmt_i_valid,
  output logic               cmt_i_ready,
  input  logic [PC_SIZE-1:0] cmt_i_pc,
  input  logic               cmt_i_bjp,
  input  logic               cmt_i_prdt,
  input  logic               cmt_i_rslv,
  input  logic [PC_SIZE-1:0] cmt_i_target,
  output logic               flush_o_valid,
  input  logic               flush_o_ready,
  output logic [PC_SIZE-1:0] flush_o_pc,
  output logic               kill_o,
  output logic [CNT_W-1:0]   bjp_cnt_o,
  output logic [CNT_W-1:0]   mispred_cnt_o
);

  if (PC_SIZE > XLEN) begin : g_bad_width
    $error("PC_SIZE must not exceed XLEN");
  end

  localparam logic [PC_SIZE-1:0] PC_STEP = PC_SIZE'(CMT_INSN_BYTES);

  logic [0:0]         state_q;
  logic [0:0]         state_d;
  logic [PC_SIZE-1:0] flush_pc_q;
  logic [PC_SIZE-1:0] flush_pc_d;
  logic               kill_q;
  logic               kill_d;

  logic               acc;
  logic               mis;
  logic [PC_SIZE-1:0] redirect_pc;

  // Ready depends on state alone, so no combinational path from valid/flush_ready.
  assign cmt_i_ready = (state_q == CMT_ST_IDLE);
  assign acc         = cmt_i_valid & cmt_i_ready;
  assign mis         = cmt_i_bjp & (cmt_i_prdt ^ cmt_i_rslv);
  assign redirect_pc = cmt_i_rslv ? cmt_i_target : cmt_i_pc + PC_STEP;

  always_comb begin
    state_d    = state_q;
    flush_pc_d = flush_pc_q;
    kill_d     = 1'b0;
    case (state_q)
      CMT_ST_IDLE: begin
        if (acc & mis) begin
          state_d    = CMT_ST_FLUSH;
          flush_pc_d = redirect_pc;
          kill_d     = 1'b1;
        end
      end
      CMT_ST_FLUSH: begin
        if (flush_o_ready) begin
          state_d = CMT_ST_IDLE;
        end
      end
      default: state_d = CMT_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CMT_ST_IDLE;
      flush_pc_q <= '0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_pc_q <= flush_pc_d;
      kill_q     <= kill_d;
    end
  end

  assign flush_o_valid = (state_q == CMT_ST_FLUSH);
  assign flush_o_pc    = flush_pc_q;
  assign kill_o        = kill_q;

  exu_cmt_cnt #(.W(CNT_W)) u_bjp_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (acc & cmt_i_bjp),
    .cnt_o (bjp_cnt_o)
  );

  exu_cmt_cnt #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (acc & mis),
    .cnt_o (mispred_cnt_o)
  );

endmodule

// File: tb/tb_exu_commit_bjp.sv
// Directed bench for exu_commit_bjp; redirect PCs are checked through a scoreboard queue.
module tb_exu_commit_bjp;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmt_i_valid;
  logic        cmt_i_ready;
  logic [31:0] cmt_i_pc;
  logic        cmt_i_bjp;
  logic        cmt_i_prdt;
  logic        cmt_i_rslv;
  logic [31:0] cmt_i_target;
  logic        flush_o_valid;
  logic        flush_o_ready;
  logic [31:0] flush_o_pc;
  logic        kill_o;
  logic [31:0] bjp_cnt_o;
  logic [31:0] mispred_cnt_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  exu_commit_bjp #(.XLEN(32), .PC_SIZE(32), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmt_i_valid   (cmt_i_valid),
    .cmt_i_ready   (cmt_i_ready),
    .cmt_i_pc      (cmt_i_pc),
    .cmt_i_bjp     (cmt_i_bjp),
    .cmt_i_prdt    (cmt_i_prdt),
    .cmt_i_rslv    (cmt_i_rslv),
    .cmt_i_target  (cmt_i_target),
    .flush_o_valid (flush_o_valid),
    .flush_o_ready (flush_o_ready),
    .flush_o_pc    (flush_o_pc),
    .kill_o        (kill_o),
    .bjp_cnt_o     (bjp_cnt_o),
    .mispred_cnt_o (mispred_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic bjp,
                       input logic prdt, input logic rslv, input logic [31:0] tgt);
    cmt_i_valid  = v;
    cmt_i_pc     = pc;
    cmt_i_bjp    = bjp;
    cmt_i_prdt   = prdt;
    cmt_i_rslv   = rslv;
    cmt_i_target = tgt;
    if (v) $display("commit pc=%h bjp=%0b prdt=%0b rslv=%0b target=%h", pc, bjp, prdt, rslv, tgt);
  endtask

  task automatic idle_state(input string name, input logic [31:0] bcnt, input logic [31:0] mcnt);
    @(negedge clk);
    chk({name, ".ready"}, {31'd0, cmt_i_ready}, 32'd1);
    chk({name, ".fvalid"}, {31'd0, flush_o_valid}, 32'd0);
    chk({name, ".kill"}, {31'd0, kill_o}, 32'd0);
    chk({name, ".bjp_cnt"}, bjp_cnt_o, bcnt);
    chk({name, ".mis_cnt"}, mispred_cnt_o, mcnt);
  endtask

  // Monitor: every completed redirect handshake must match the oldest expected PC.
  always @(negedge clk) begin
    if (!rst && flush_o_valid && flush_o_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL flush_unexpected at %0t: got pc %h, expected no redirect", $time, flush_o_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        $display("redirect pc=%h", flush_o_pc);
        if (flush_o_pc !== e) begin
          errors++;
          $display("FAIL flush_pc at %0t: got %h, expected %h", $time, flush_o_pc, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush_o_ready = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    rst = 1'b0;

    // Reset state held with no traffic
    for (int i = 0; i < 5; i++) begin
      idle_state("reset_idle", 32'd0, 32'd0);
      step();
    end

    // Four back-to-back correct predictions
    drive(1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 32'h8000_0040);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b.ready", {31'd0, cmt_i_ready}, 32'd1);
      chk("b2b.fvalid", {31'd0, flush_o_valid}, 32'd0);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    idle_state("b2b_done", 32'd4, 32'd0);

    // Mispredicted not-taken, IFU ready immediately
    flush_o_ready = 1'b1;
    drive(1'b1, 32'h8000_0010, 1'b1, 1'b1, 1'b0, 32'h8000_0200);
    exp_q.push_back(32'h8000_0014);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("mis_nt.fvalid", {31'd0, flush_o_valid}, 32'd1);
    chk("mis_nt.kill", {31'd0, kill_o}, 32'd1);
    chk("mis_nt.pc", flush_o_pc, 32'h8000_0014);
    chk("mis_nt.ready", {31'd0, cmt_i_ready}, 32'd0);
    step();
    idle_state("mis_nt_done", 32'd5, 32'd1);

    // Mispredicted taken, IFU stalls three cycles
    flush_o_ready = 1'b0;
    drive(1'b1, 32'h8000_0020, 1'b1, 1'b0, 1'b1, 32'h8000_0100);
    exp_q.push_back(32'h8000_0100);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) flush_o_ready = 1'b1;
      @(negedge clk);
      chk("mis_t.fvalid", {31'd0, flush_o_valid}, 32'd1);
      chk("mis_t.pc", flush_o_pc, 32'h8000_0100);
      chk("mis_t.kill", {31'd0, kill_o}, (i == 0) ? 32'd1 : 32'd0);
      chk("mis_t.ready", {31'd0, cmt_i_ready}, 32'd0);
      step();
    end
    idle_state("mis_t_done", 32'd6, 32'd2);

    // PC wrap on not-taken redirect
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 32'h1234_5678);
    exp_q.push_back(32'h0000_0000);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("wrap.fvalid", {31'd0, flush_o_valid}, 32'd1);
    chk("wrap.pc", flush_o_pc, 32'h0000_0000);
    step();
    idle_state("wrap_done", 32'd7, 32'd2 + 32'd1);

    // Non-bjp with disagreeing prediction fields is not a mispredict
    drive(1'b1, 32'h8000_0300, 1'b0, 1'b1, 1'b0, 32'h8000_0400);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    idle_state("nonbjp", 32'd7, 32'd3);

    // Reset while a redirect is pending
    flush_o_ready = 1'b0;
    drive(1'b1, 32'h8000_0500, 1'b1, 1'b0, 1'b1, 32'h8000_0600);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("rst_flush.fvalid_before", {31'd0, flush_o_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_state("rst_flush", 32'd0, 32'd0);
    step();
    idle_state("rst_flush_after", 32'd0, 32'd0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exu_commit_bjp.md
# exu_commit_bjp

Branch/jump commit unit. It sits at the consuming end of the EXU branch/jump result interface and accepts one resolved branch or jump per handshake. It compares the predicted direction with the resolved direction. On a mispredict it kills younger instructions and issues a redirect (flush) request to the IFU over a second valid/ready handshake. It also keeps wrap-around counters of committed branches/jumps and of mispredicts.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `PC_SIZE`, 32: PC width.
- `CNT_W`, 32: statistics counter width.

Ports (clock and reset first):
- `clk`  in  1  clock. One clock; all state updates on rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `cmt_i_valid`  in  1  commit request valid.
- `cmt_i_ready`  out  1  commit request accepted.
- `cmt_i_pc`  in  PC_SIZE  PC of the committing instruction.
- `cmt_i_bjp`  in  1  instruction is a branch/jump; 0 = non-control instruction (pass-through).
- `cmt_i_prdt`  in  1  predicted taken.
- `cmt_i_rslv`  in  1  resolved taken (always 1 for jumps).
- `cmt_i_target`  in  PC_SIZE  resolved taken target.
- `flush_o_valid`  out  1  redirect request to IFU.
- `flush_o_ready`  in  1  IFU accepts redirect.
- `flush_o_pc`  out  PC_SIZE  redirect PC.
- `kill_o`  out  1  one-cycle pulse: squash younger in-flight instructions.
- `bjp_cnt_o`  out  CNT_W  committed branch/jump count.
- `mispred_cnt_o`  out  CNT_W  mispredict count.

## Operation
- Accept: `acc = cmt_i_valid & cmt_i_ready`.
- Mispredict: `mis = cmt_i_bjp & (cmt_i_prdt ^ cmt_i_rslv)`.
- Redirect PC:
  - `cmt_i_rslv ? cmt_i_target : cmt_i_pc + 4`.
  - The add is PC_SIZE wide and wraps modulo 2^PC_SIZE; the carry is dropped.
- FSM has two states.
  - IDLE:
    - `cmt_i_ready=1`, `flush_o_valid=0`.
    - On `acc & mis`: register the redirect PC into `flush_o_pc`, go to FLUSH.
    - On `acc & ~mis`: stay in IDLE.
  - FLUSH:
    - `cmt_i_ready=0`, `flush_o_valid=1`, `flush_o_pc` held stable.
    - On `flush_o_ready`: go to IDLE.
    - Otherwise stay in FLUSH indefinitely; valid is never dropped.
- `kill_o` is 1 exactly in the first cycle of FLUSH, i.e. the cycle after the mispredicting accept. It is registered.
- Counters:
  - `bjp_cnt_o` increments on `acc & cmt_i_bjp`.
  - `mispred_cnt_o` increments on `acc & mis`.
  - Both wrap from all-ones to 0.
  - Non-bjp accepts change neither counter.
- Inconsistent input: `cmt_i_bjp=0` with `prdt != rslv` is not a mispredict. Prediction fields are ignored when `bjp=0`.

## Timing
- Reset values:
  - FSM = IDLE.
  - `cmt_i_ready=1`, `flush_o_valid=0`, `flush_o_pc=0`, `kill_o=0`.
  - Both counters 0.
- Reset asserted in FLUSH: the next cycle is IDLE with `flush_o_valid=0`. The pending redirect is dropped.
- Correct prediction: accepted in 0 wait cycles. Back-to-back accepts every cycle are allowed.
- Mispredict, cycle by cycle:
  - Cycle N: accept.
  - Cycle N+1: `flush_o_valid=1`, `kill_o=1`.
  - Cycle N+k: `flush_o_ready` handshake completes.
  - Cycle N+k+1: IDLE, `cmt_i_ready=1`.
- Minimum gap from a mispredicting accept to the next accept is 2 cycles, reached when `flush_o_ready=1` at N+1.
- `cmt_i_ready` is a function of state only; there is no combinational path from `cmt_i_valid` or `flush_o_ready`.
- `flush_o_ready` has no effect in IDLE.
- Counter values are visible the cycle after the accept.

## Structure
- Widths come from the shared `defines.v`: `XLEN`, `PC_SIZE`.
- Add to `defines.v`:
  - `CMT_ST_IDLE=1'b0`, `CMT_ST_FLUSH=1'b1`.
  - `CMT_CNT_W=32`.
- One sub-module: `exu_cmt_cnt`, a CNT_W wrap-around counter with enable and sync reset. It is instantiated twice.
- All flops use sync reset on `rst`.

## Test plan
- Reset, then `cmt_i_valid=0` for 5 cycles. Required: `cmt_i_ready=1`, `flush_o_valid=0`, `kill_o=0`, counters 0 throughout.
- 4 back-to-back correctly predicted branches (`bjp=1`, `prdt=rslv=1`). Required: accepted every cycle, no flush, `bjp_cnt_o=4`, `mispred_cnt_o=0`.
- Mispredicted not-taken (`pc=0x8000_0010`, `prdt=1`, `rslv=0`), `flush_o_ready=1`. Required at N+1: `flush_o_pc=0x8000_0014`, `flush_o_valid=1`, `kill_o=1`. At N+2: IDLE, `mispred_cnt_o=1`.
- Mispredicted taken (`target=0x8000_0100`, `prdt=0`, `rslv=1`), `flush_o_ready` low for 3 cycles. Required:
  - `flush_o_valid` and `flush_o_pc` stable for 4 cycles.
  - `kill_o` high only on the first of them.
  - `cmt_i_ready=0` until the cycle after the handshake.
- Edge cases:
  - `pc=0xFFFF_FFFC`, mispredicted not-taken. Required: `flush_o_pc=0x0000_0000`.
  - `bjp=0` with `prdt=1`, `rslv=0`. Required: no flush, counters unchanged.
- `rst` pulsed while in FLUSH. Required: next cycle `flush_o_valid=0`, `cmt_i_ready=1`, counters 0.
